// File: rtl/join_pkg.sv
// Shared FSM encoding, default sizing and phase helpers for the four-phase N-way join.
package join_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRE    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RTZ     = 2'd3
  } join_state_e;

  localparam int JOIN_N_CH  = 2;
  localparam int JOIN_WIDTH = 8;
  localparam int JOIN_CNT_W = 16;

  function automatic logic f_req_phase(input join_state_e s);
    return (s == ST_FIRE) || (s == ST_RELEASE);
  endfunction

  function automatic logic f_ack_phase(input join_state_e s);
    return (s == ST_RELEASE) || (s == ST_RTZ);
  endfunction

endpackage

// File: rtl/join_slot.sv
// One upstream channel of the join: arrival capture, first-cycle data latch and
// withdrawal detection. Only moves while the join is idle.
module join_slot
  import join_pkg::*;
#(
  parameter int WIDTH = JOIN_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_idle,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_cap_nxt,
  output logic [WIDTH-1:0] o_data_nxt,
  output logic             o_withdraw
);

  logic             r_cap;
  logic [WIDTH-1:0] r_data;
  logic             w_take;

  // A still-held request keeps its first-cycle data; a dropped one must re-arrive.
  assign w_take     = i_idle & i_en & i_req & ~r_cap;
  assign o_cap_nxt  = i_en & i_req;
  assign o_withdraw = i_idle & i_en & r_cap & ~i_req;
  assign o_data_nxt = w_take ? i_data : r_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cap  <= 1'b0;
      r_data <= {WIDTH{1'b0}};
    end else if (i_clear) begin
      r_cap  <= 1'b0;
    end else if (i_idle) begin
      r_cap <= o_cap_nxt;
      if (w_take) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/join_n.sv
// Four-phase N-way join: waits for every enabled upstream request, forwards one
// joined request downstream, then returns all handshakes to zero together.
module join_n
  import join_pkg::*;
#(
  parameter int N_CH  = JOIN_N_CH,
  parameter int WIDTH = JOIN_WIDTH,
  parameter int CNT_W = JOIN_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_req,
  output logic [N_CH-1:0]       in_ack,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       ch_mask,
  output logic                  out_req,
  input  logic                  out_ack,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      txn_count,
  output logic                  proto_err
);

  join_state_e           r_state;
  join_state_e           w_state_nxt;
  logic [N_CH-1:0]       r_act;
  logic [N_CH-1:0]       r_in_ack;
  logic [N_CH-1:0]       w_in_ack_nxt;
  logic                  r_out_req;
  logic                  w_out_req_nxt;
  logic [N_CH*WIDTH-1:0] r_out_data;
  logic [N_CH*WIDTH-1:0] w_data_nxt;
  logic [N_CH*WIDTH-1:0] w_data_masked;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_err;
  logic [N_CH-1:0]       w_cap_nxt;
  logic [N_CH-1:0]       w_withdraw;
  logic                  w_idle;
  logic                  w_fire;
  logic                  w_done;
  logic                  w_err_set;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_fire    = w_idle && (ch_mask != {N_CH{1'b0}}) && (w_cap_nxt == ch_mask);
  assign w_done    = (r_state == ST_RTZ) && !out_ack;
  assign w_err_set = (|w_withdraw)
                   || ((r_state == ST_FIRE) && (|(r_act & ~in_req)))
                   || (w_idle && out_ack);

  for (genvar g = 0; g < N_CH; g++) begin : g_slot
    join_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_idle     (w_idle),
      .i_clear    (w_done),
      .i_en       (ch_mask[g]),
      .i_req      (in_req[g]),
      .i_data     (in_data[g*WIDTH +: WIDTH]),
      .o_cap_nxt  (w_cap_nxt[g]),
      .o_data_nxt (w_data_nxt[g*WIDTH +: WIDTH]),
      .o_withdraw (w_withdraw[g])
    );
    assign w_data_masked[g*WIDTH +: WIDTH] =
      ch_mask[g] ? w_data_nxt[g*WIDTH +: WIDTH] : {WIDTH{1'b0}};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_fire)                              w_state_nxt = ST_FIRE;    else w_state_nxt = ST_IDLE;
      ST_FIRE:    if (out_ack)                             w_state_nxt = ST_RELEASE; else w_state_nxt = ST_FIRE;
      ST_RELEASE: if ((in_req & r_act) == {N_CH{1'b0}})    w_state_nxt = ST_RTZ;     else w_state_nxt = ST_RELEASE;
      ST_RTZ:     if (!out_ack)                            w_state_nxt = ST_IDLE;    else w_state_nxt = ST_RTZ;
      default:                                             w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they register cleanly.
  always_comb begin
    w_out_req_nxt = f_req_phase(w_state_nxt);
    if (f_ack_phase(w_state_nxt)) begin
      w_in_ack_nxt = r_act;
    end else begin
      w_in_ack_nxt = {N_CH{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_act      <= {N_CH{1'b0}};
      r_out_req  <= 1'b0;
      r_in_ack   <= {N_CH{1'b0}};
      r_out_data <= {(N_CH*WIDTH){1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
      r_err      <= 1'b0;
    end else begin
      r_out_req <= w_out_req_nxt;
      r_in_ack  <= w_in_ack_nxt;
      if (w_fire) begin
        r_act      <= ch_mask;
        r_out_data <= w_data_masked;
      end
      if (w_done) begin
        r_cnt <= r_cnt + CNT_W'(1'b1);
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign in_ack    = r_in_ack;
  assign out_req   = r_out_req;
  assign out_data  = r_out_data;
  assign txn_count = r_cnt;
  assign proto_err = r_err;

endmodule

// File: tb/tb_join_n.sv
// Directed self-checking bench for join_n (N_CH=3, WIDTH=8, CNT_W=4).
module tb_join_n;

  logic        clk;
  logic        rst;
  logic [2:0]  in_req;
  logic [2:0]  in_ack;
  logic [23:0] in_data;
  logic [2:0]  ch_mask;
  logic        out_req;
  logic        out_ack;
  logic [23:0] out_data;
  logic [3:0]  txn_count;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  join_n #(.N_CH(3), .WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_req    (in_req),
    .in_ack    (in_ack),
    .in_data   (in_data),
    .ch_mask   (ch_mask),
    .out_req   (out_req),
    .out_ack   (out_ack),
    .out_data  (out_data),
    .txn_count (txn_count),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; in_req = 3'b000; out_ack = 1'b0; in_data = 24'h0; ch_mask = 3'b111;
    tick(); tick();
    rst = 1'b1;
  endtask

  // Full handshake with all three channels, no checks; leaves the DUT back in IDLE.
  task automatic run_txn(input logic [23:0] d);
    in_req = 3'b111; in_data = d; tick();
    out_ack = 1'b1; tick();
    in_req = 3'b000; tick();
    out_ack = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_req = 3'b111; out_ack = 1'b1; in_data = 24'hFFFFFF; ch_mask = 3'b111;
    tick(); tick();
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL rst_out_req: got %0h want 0", out_req); end
    checks++; if (in_ack !== 3'b000) begin errors++; $display("FAIL rst_in_ack: got %0h want 0", in_ack); end
    checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
    checks++; if (txn_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0h want 0", txn_count); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0h want 0", proto_err); end
    in_req = 3'b000; out_ack = 1'b0; in_data = 24'h0; rst = 1'b1;
  endtask

  task automatic test_staggered();
    apply_reset();
    in_req = 3'b001; in_data = 24'h000011; tick();
    in_data = 24'h0000EE; tick(); tick(); tick();
    in_req = 3'b011; in_data = 24'h0022EE; tick(); tick(); tick();
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL stag_early_req: got %0h want 0", out_req); end
    in_req = 3'b111; in_data = 24'h3322EE; tick();
    checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL stag_out_req: got %0h want 1", out_req); end
    checks++; if (out_data !== 24'h332211) begin errors++; $display("FAIL stag_out_data: got %0h want 332211", out_data); end
    checks++; if (in_ack !== 3'b000) begin errors++; $display("FAIL stag_fire_ack: got %0h want 0", in_ack); end
    out_ack = 1'b1; tick();
    checks++; if (in_ack !== 3'b111) begin errors++; $display("FAIL stag_in_ack: got %0h want 7", in_ack); end
    checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL stag_rel_req: got %0h want 1", out_req); end
    in_req = 3'b000; tick();
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL stag_rtz_req: got %0h want 0", out_req); end
    checks++; if (in_ack !== 3'b111) begin errors++; $display("FAIL stag_rtz_ack: got %0h want 7", in_ack); end
    out_ack = 1'b0; tick();
    checks++; if (in_ack !== 3'b000) begin errors++; $display("FAIL stag_idle_ack: got %0h want 0", in_ack); end
    checks++; if (txn_count !== 4'd1) begin errors++; $display("FAIL stag_count: got %0h want 1", txn_count); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL stag_err: got %0h want 0", proto_err); end
  endtask

  task automatic test_masked();
    apply_reset();
    ch_mask = 3'b101; in_req = 3'b101; in_data = 24'h665544; tick();
    checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL mask_out_req: got %0h want 1", out_req); end
    checks++; if (out_data !== 24'h660044) begin errors++; $display("FAIL mask_out_data: got %0h want 660044", out_data); end
    in_req = 3'b111; out_ack = 1'b1; tick();
    checks++; if (in_ack !== 3'b101) begin errors++; $display("FAIL mask_in_ack: got %0h want 5", in_ack); end
    in_req = 3'b010; ch_mask = 3'b111; tick();
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL mask_rtz_req: got %0h want 0", out_req); end
    checks++; if (in_ack !== 3'b101) begin errors++; $display("FAIL mask_rtz_ack: got %0h want 5", in_ack); end
    out_ack = 1'b0; in_req = 3'b000; tick();
    checks++; if (in_ack !== 3'b000) begin errors++; $display("FAIL mask_idle_ack: got %0h want 0", in_ack); end
    checks++; if (txn_count !== 4'd1) begin errors++; $display("FAIL mask_count: got %0h want 1", txn_count); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mask_err: got %0h want 0", proto_err); end
  endtask

  task automatic test_zero_mask();
    apply_reset();
    ch_mask = 3'b000; in_req = 3'b111; in_data = 24'h123456; tick(); tick(); tick();
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL zmask_out_req: got %0h want 0", out_req); end
    checks++; if (in_ack !== 3'b000) begin errors++; $display("FAIL zmask_in_ack: got %0h want 0", in_ack); end
    checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL zmask_out_data: got %0h want 0", out_data); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL zmask_err: got %0h want 0", proto_err); end
  endtask

  task automatic test_withdrawal();
    apply_reset();
    in_req = 3'b011; in_data = 24'h002211; tick(); tick();
    in_req = 3'b001;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL wd_err_early: got %0h want 0", proto_err); end
    tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL wd_err: got %0h want 1", proto_err); end
    in_req = 3'b101; in_data = 24'h330011; tick();
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL wd_no_fire: got %0h want 0", out_req); end
    in_req = 3'b111; in_data = 24'h337711; tick();
    checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL wd_fire: got %0h want 1", out_req); end
    checks++; if (out_data !== 24'h337711) begin errors++; $display("FAIL wd_out_data: got %0h want 337711", out_data); end
    out_ack = 1'b1; tick();
    in_req = 3'b000; tick();
    out_ack = 1'b0; tick();
    checks++; if (txn_count !== 4'd1) begin errors++; $display("FAIL wd_count: got %0h want 1", txn_count); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %0h want 1", proto_err); end
  endtask

  task automatic test_fire_drop();
    apply_reset();
    in_req = 3'b111; in_data = 24'h0A0B0C; tick();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL fdrop_err_early: got %0h want 0", proto_err); end
    in_req = 3'b110; tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL fdrop_err: got %0h want 1", proto_err); end
    checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL fdrop_req: got %0h want 1", out_req); end
    out_ack = 1'b1; tick();
    checks++; if (in_ack !== 3'b111) begin errors++; $display("FAIL fdrop_ack: got %0h want 7", in_ack); end
    in_req = 3'b000; tick();
    out_ack = 1'b0; tick();
    checks++; if (txn_count !== 4'd1) begin errors++; $display("FAIL fdrop_count: got %0h want 1", txn_count); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    in_req = 3'b111; in_data = 24'hABCDEF; tick();
    out_ack = 1'b1; tick();
    checks++; if (in_ack !== 3'b111) begin errors++; $display("FAIL mrst_pre_ack: got %0h want 7", in_ack); end
    rst = 1'b0; tick();
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL mrst_out_req: got %0h want 0", out_req); end
    checks++; if (in_ack !== 3'b000) begin errors++; $display("FAIL mrst_in_ack: got %0h want 0", in_ack); end
    checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL mrst_out_data: got %0h want 0", out_data); end
    checks++; if (txn_count !== 4'd0) begin errors++; $display("FAIL mrst_count: got %0h want 0", txn_count); end
    rst = 1'b1; in_req = 3'b000; out_ack = 1'b0; tick(); tick();
    checks++; if (txn_count !== 4'd0) begin errors++; $display("FAIL mrst_count_after: got %0h want 0", txn_count); end
  endtask

  task automatic test_spurious_ack();
    apply_reset();
    out_ack = 1'b1; tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL spur_err: got %0h want 1", proto_err); end
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL spur_out_req: got %0h want 0", out_req); end
    out_ack = 1'b0; tick();
    in_req = 3'b111; in_data = 24'h010203; tick();
    checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL spur_fire: got %0h want 1", out_req); end
    checks++; if (out_data !== 24'h010203) begin errors++; $display("FAIL spur_out_data: got %0h want 010203", out_data); end
    out_ack = 1'b1; tick();
    in_req = 3'b000; tick();
    out_ack = 1'b0; tick();
    checks++; if (txn_count !== 4'd1) begin errors++; $display("FAIL spur_count: got %0h want 1", txn_count); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_cnt;
    apply_reset();
    exp_cnt = 4'd0;
    for (int i = 0; i < 17; i++) begin
      run_txn(24'(i * 3));
      exp_cnt = exp_cnt + 4'd1;
      checks++; if (txn_count !== exp_cnt) begin errors++; $display("FAIL b2b_count[%0d]: got %0h want %0h", i, txn_count, exp_cnt); end
    end
    checks++; if (txn_count !== 4'd1) begin errors++; $display("FAIL b2b_wrap: got %0h want 1", txn_count); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %0h want 0", proto_err); end
  endtask

  initial begin
    rst = 1'b0; in_req = 3'b000; out_ack = 1'b0; in_data = 24'h0; ch_mask = 3'b111;
    test_reset();
    test_staggered();
    test_masked();
    test_zero_mask();
    test_withdrawal();
    test_fire_drop();
    test_mid_reset();
    test_spurious_ack();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/join_n.md
JOIN_N -- requirements
Module: join_n

Interface
REQ-001 Parameter N_CH, default 2: number of upstream channels, legal range 2..8.
REQ-002 Parameter WIDTH, default 8: data bits per channel, legal range 1..64.
REQ-003 Parameter CNT_W, default 16: width of the transaction counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 in_req  input  N_CH  four-phase request, one bit per upstream channel.
REQ-007 in_ack  output  N_CH  four-phase acknowledge, one bit per upstream channel.
REQ-008 in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 ch_mask  input  N_CH  1 = channel takes part in the join; sampled only in IDLE.
REQ-010 out_req  output  1  joined four-phase request to downstream.
REQ-011 out_ack  input  1  four-phase acknowledge from downstream.
REQ-012 out_data  output  N_CH*WIDTH  captured data, in the same layout as in_data.
REQ-013 txn_count  output  CNT_W  number of completed joins.
REQ-014 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-015 FSM states: IDLE, FIRE, RELEASE, RTZ; all transitions are registered.
REQ-016 IDLE: each enabled channel i sets captured[i] and latches its data on the first cycle in_req[i]=1.
REQ-017 IDLE->FIRE: in the cycle after every enabled channel is captured (captured & ch_mask == ch_mask, ch_mask != 0).
- Latch the active mask at this transition.
- out_req=1 from that cycle on.
REQ-018 ch_mask all-zero: stay in IDLE, no output activity.
REQ-019 FIRE->RELEASE: on out_ack=1; in_ack[i]=1 for active channels from the next cycle.
REQ-020 RELEASE->RTZ: when in_req=0 on every active channel; out_req=0 from the next cycle.
REQ-021 RTZ->IDLE: on out_ack=0.
- Next cycle: in_ack=0, captured cleared, txn_count incremented by 1.
REQ-022 txn_count wraps from 2^CNT_W-1 to 0.
REQ-023 out_data is stable and valid whenever out_req=1.
- Masked channel slices read zero.
- Data is never updated outside IDLE.
REQ-024 Inactive or masked channels: in_ack=0 at all times; their in_req is ignored.
REQ-025 Withdrawal violation: a captured active channel drops in_req while in IDLE.
- Set proto_err.
- Clear that channel's captured bit; its next rising request is treated as a fresh arrival.
REQ-026 Active channel drops in_req in FIRE: set proto_err; the FSM proceeds normally.
REQ-027 out_ack=1 observed in IDLE: set proto_err; out_ack is otherwise ignored.
REQ-028 ch_mask changes outside IDLE have no effect on the transaction in flight.

Reset
REQ-029 While rst=0 at a clock edge:
- state=IDLE, in_ack=0, out_req=0, out_data=0.
- captured=0, txn_count=0, proto_err=0.
REQ-030 Reset mid-transaction aborts it: no count increment, outputs return to reset values the next cycle.
REQ-031 proto_err clears only on reset.

Structure
REQ-032 Package join_pkg holds the FSM state enum and the default N_CH, WIDTH and CNT_W constants.
REQ-033 One sub-module, join_slot: per-channel captured flag, data latch and withdrawal detect; instantiated N_CH times via generate.
REQ-034 The FSM, counter and error logic reside in join_n; no combinational path from in_req or out_ack to any output.

Verification (N_CH=3, WIDTH=8, ch_mask=3'b111 unless stated)
REQ-035 Staggered arrival:
- Stimulus: in_req[0] at cycle 0 with data 0x11, in_req[1] at cycle 4 with 0x22, in_req[2] at cycle 7 with 0x33.
- Response: out_req rises at cycle 8, out_data=0x332211; after the full handshake txn_count=1.
REQ-036 Masked channel:
- Stimulus: ch_mask=3'b101; channels 0 and 2 request.
- Response: join fires; in_ack=3'b101; out_data slice 1 = 0x00; in_req[1] toggling has no effect.
REQ-037 Withdrawal:
- Stimulus: in_req[1] high for 2 cycles, then low in IDLE.
- Response: proto_err=1; no fire until channel 1 re-requests.
REQ-038 Mid-transaction reset:
- Stimulus: rst=0 in RELEASE.
- Response: next cycle out_req=0, in_ack=0, txn_count unchanged (0).
REQ-039 Counter wrap:
- Stimulus: CNT_W=4, 17 back-to-back transactions.
- Response: txn_count reads 1, proto_err=0.
REQ-040 Spurious acknowledge:
- Stimulus: out_ack=1 in IDLE.
- Response: proto_err=1; state stays IDLE.
